// File: rtl/stopwatch_keys.sv
// stopwatch_keys: push-button front-end for the stopwatch.
// Syncs and debounces left/down/up keys and time_out in the 100 MHz domain.
// Ports:
//   clk_100mhz, rst      : clock, synchronous active-high reset
//   key_left/down/up     : raw buttons (async, 1 = pressed)
//   time_out             : preset-reached flag from the 100 Hz counter (async)
//   sw_en, pause, clear  : registered command levels for the counter
//   key_evt              : registered one-cycle pulse per accepted press
module stopwatch_keys #(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int CLEAR_HOLD_CYCLES = 2_000_000,
  parameter int CNT_W             = 21
) (
  input  logic clk_100mhz,
  input  logic rst,
  input  logic key_left,
  input  logic key_down,
  input  logic key_up,
  input  logic time_out,
  output logic sw_en,
  output logic pause,
  output logic clear,
  output logic key_evt
);

  localparam logic [CNT_W-1:0] DB_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX =
    CNT_W'(CLEAR_HOLD_CYCLES - 1);

  typedef enum logic {
    IDLE,
    CLEARING
  } state_t;

  state_t           state;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic             to_d;
  logic [2:0]       db;
  logic [2:0]       db_d;
  logic [2:0]       press;
  logic             to_rise;
  logic [CNT_W-1:0] hold;

  // bit 0 left, 1 down, 2 up, 3 time_out
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      to_d  <= 1'b0;
      db_d  <= '0;
    end else begin
      sync1 <= {time_out, key_up, key_down, key_left};
      sync2 <= sync1;
      to_d  <= sync2[3];
      db_d  <= db;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [CNT_W-1:0] cnt;
    logic             q;

    // Accept a change only after DEBOUNCE_CYCLES
    // consecutive disagreeing samples.
    always_ff @(posedge clk_100mhz) begin
      if (rst) begin
        cnt <= '0;
        q   <= 1'b0;
      end else if (sync2[i] == q) begin
        cnt <= '0;
      end else if (cnt == DB_MAX) begin
        q   <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign db[i] = q;
  end

  assign press   = db & ~db_d;
  assign to_rise = sync2[3] & ~to_d;

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state   <= IDLE;
      sw_en   <= 1'b0;
      pause   <= 1'b0;
      clear   <= 1'b0;
      key_evt <= 1'b0;
      hold    <= '0;
    end else begin
      key_evt <= 1'b0;
      case (state)
        IDLE: begin
          if (press[2]) begin
            // clear overrides any toggle on the same cycle
            state   <= CLEARING;
            clear   <= 1'b1;
            sw_en   <= 1'b0;
            pause   <= 1'b0;
            hold    <= '0;
            key_evt <= 1'b1;
          end else begin
            if (press[0]) sw_en <= ~sw_en;
            if (press[1]) pause <= ~pause;
            key_evt <= press[0] | press[1];
          end
        end
        CLEARING: begin
          hold <= hold + CNT_W'(1);
          if (hold == HOLD_MAX) begin
            clear <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // timeout beats a same-cycle left toggle
      if (to_rise) sw_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stopwatch_keys.sv
// tb_stopwatch_keys: directed and random checks of stopwatch_keys
// against a sample-history reference model.
module tb_stopwatch_keys;

  localparam int DB = 4;
  localparam int CH = 8;

  logic clk_100mhz = 1'b0;
  logic rst        = 1'b1;
  logic key_left   = 1'b0;
  logic key_down   = 1'b0;
  logic key_up     = 1'b0;
  logic time_out   = 1'b0;
  logic sw_en;
  logic pause;
  logic clear;
  logic key_evt;

  int passed = 0;
  int total  = 0;

  stopwatch_keys #(
    .DEBOUNCE_CYCLES  (DB),
    .CLEAR_HOLD_CYCLES(CH),
    .CNT_W            (21)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .rst       (rst),
    .key_left  (key_left),
    .key_down  (key_down),
    .key_up    (key_up),
    .time_out  (time_out),
    .sw_en     (sw_en),
    .pause     (pause),
    .clear     (clear),
    .key_evt   (key_evt)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // Reference model: raw samples per edge since reset,
  // debounced key levels after each edge.
  logic [3:0] raw_q[$];
  logic [2:0] db_q[$];
  int   ecnt     = 0;
  int   clr_left = 0;
  logic m_sw     = 1'b0;
  logic m_pause  = 1'b0;
  logic m_clear  = 1'b0;
  logic m_evt    = 1'b0;

  function automatic logic [3:0] raw_at(int k);
    return (k >= 1) ? raw_q[k-1] : 4'b0000;
  endfunction

  function automatic logic [2:0] db_at(int k);
    return (k >= 1) ? db_q[k-1] : 3'b000;
  endfunction

  always @(posedge clk_100mhz) begin : model
    logic [2:0] prev;
    logic [2:0] pprev;
    logic [2:0] pr;
    logic [2:0] nd;
    logic [3:0] r0;
    logic [3:0] r1;
    logic       flip;
    if (rst) begin
      raw_q.delete();
      db_q.delete();
      ecnt     = 0;
      clr_left = 0;
      m_sw     = 1'b0;
      m_pause  = 1'b0;
      m_clear  = 1'b0;
      m_evt    = 1'b0;
    end else begin
      ecnt++;
      raw_q.push_back({time_out, key_up, key_down, key_left});
      prev  = db_at(ecnt - 1);
      pprev = db_at(ecnt - 2);
      pr    = prev & ~pprev;
      r0    = raw_at(ecnt - 2);
      r1    = raw_at(ecnt - 3);
      m_evt = 1'b0;
      if (clr_left > 0) begin
        clr_left--;
        if (clr_left == 0) m_clear = 1'b0;
      end else if (pr[2]) begin
        m_clear  = 1'b1;
        m_sw     = 1'b0;
        m_pause  = 1'b0;
        clr_left = CH;
        m_evt    = 1'b1;
      end else begin
        if (pr[0]) m_sw = ~m_sw;
        if (pr[1]) m_pause = ~m_pause;
        m_evt = pr[0] | pr[1];
      end
      if (r0[3] && !r1[3]) m_sw = 1'b0;
      // a key flips once its last DB synced samples all disagree
      nd = prev;
      for (int i = 0; i < 3; i++) begin
        flip = 1'b1;
        for (int j = 0; j < DB; j++) begin
          r0 = raw_at(ecnt - 2 - j);
          if (r0[i] == prev[i]) flip = 1'b0;
        end
        if (flip) nd[i] = ~prev[i];
      end
      db_q.push_back(nd);
    end
  end

  task automatic test_reset;
    repeat (3) @(negedge clk_100mhz);
    total++;
    if ({sw_en, pause, clear, key_evt} !== 4'b0000)
      $display("FAIL reset: got %b expected 0000",
               {sw_en, pause, clear, key_evt});
    else passed++;
  endtask

  task automatic test_left;
    int n;
    int e0;
    logic [3:0] exp;
    rst      = 1'b0;
    key_left = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_100mhz);
      n   = ecnt;
      exp = {(n >= 7), 1'b0, 1'b0, (n == 7)};
      total++;
      if ({sw_en, pause, clear, key_evt} !== exp)
        $display("FAIL left_on n=%0d: got %b expected %b",
                 n, {sw_en, pause, clear, key_evt}, exp);
      else passed++;
    end
    key_left = 1'b0;
    repeat (10) @(negedge clk_100mhz);
    key_left = 1'b1;
    e0 = ecnt;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_100mhz);
      n   = ecnt - e0;
      exp = {(n < 7), 1'b0, 1'b0, (n == 7)};
      total++;
      if ({sw_en, pause, clear, key_evt} !== exp)
        $display("FAIL left_off n=%0d: got %b expected %b",
                 n, {sw_en, pause, clear, key_evt}, exp);
      else passed++;
    end
    key_left = 1'b0;
    repeat (8) @(negedge clk_100mhz);
  endtask

  task automatic test_both;
    int n;
    int e0;
    logic [3:0] exp;
    key_left = 1'b1;
    key_down = 1'b1;
    e0 = ecnt;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_100mhz);
      n   = ecnt - e0;
      exp = {(n >= 7), (n >= 7), 1'b0, (n == 7)};
      total++;
      if ({sw_en, pause, clear, key_evt} !== exp)
        $display("FAIL both n=%0d: got %b expected %b",
                 n, {sw_en, pause, clear, key_evt}, exp);
      else passed++;
    end
    key_left = 1'b0;
    key_down = 1'b0;
    repeat (8) @(negedge clk_100mhz);
  endtask

  task automatic test_clear;
    int n;
    int e0;
    logic [3:0] exp;
    key_up = 1'b1;
    e0 = ecnt;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_100mhz);
      n   = ecnt - e0;
      exp = {(n < 7), (n < 7), (n >= 7 && n < 7 + CH), (n == 7)};
      total++;
      if ({sw_en, pause, clear, key_evt} !== exp)
        $display("FAIL clear n=%0d: got %b expected %b",
                 n, {sw_en, pause, clear, key_evt}, exp);
      else passed++;
      if (n == 4) key_left = 1'b1;
    end
    key_up   = 1'b0;
    key_left = 1'b0;
    repeat (8) @(negedge clk_100mhz);
  endtask

  task automatic test_glitch;
    int n;
    int e0;
    logic [3:0] exp;
    for (int b = 0; b < 10; b++) begin
      key_down = (b % 2 == 0);
      repeat (3) begin
        @(negedge clk_100mhz);
        total++;
        if ({pause, key_evt} !== 2'b00)
          $display("FAIL glitch b=%0d: got %b expected 00",
                   b, {pause, key_evt});
        else passed++;
      end
    end
    key_down = 1'b1;
    e0 = ecnt;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_100mhz);
      n   = ecnt - e0;
      exp = {1'b0, (n >= 7), 1'b0, (n == 7)};
      total++;
      if ({sw_en, pause, clear, key_evt} !== exp)
        $display("FAIL glitch_press n=%0d: got %b expected %b",
                 n, {sw_en, pause, clear, key_evt}, exp);
      else passed++;
    end
    key_down = 1'b0;
    repeat (8) @(negedge clk_100mhz);
  endtask

  task automatic test_timeout;
    int n;
    int e0;
    logic [3:0] exp;
    key_left = 1'b1;
    e0 = ecnt;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_100mhz);
      n   = ecnt - e0;
      exp = {(n >= 7), 1'b1, 1'b0, (n == 7)};
      total++;
      if ({sw_en, pause, clear, key_evt} !== exp)
        $display("FAIL to_start n=%0d: got %b expected %b",
                 n, {sw_en, pause, clear, key_evt}, exp);
      else passed++;
    end
    key_left = 1'b0;
    repeat (8) @(negedge clk_100mhz);
    time_out = 1'b1;
    e0 = ecnt;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_100mhz);
      n   = ecnt - e0;
      exp = {(n < 3), 1'b1, 1'b0, 1'b0};
      total++;
      if ({sw_en, pause, clear, key_evt} !== exp)
        $display("FAIL to_stop n=%0d: got %b expected %b",
                 n, {sw_en, pause, clear, key_evt}, exp);
      else passed++;
    end
    time_out = 1'b0;
    repeat (4) @(negedge clk_100mhz);
    key_left = 1'b1;
    e0 = ecnt;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_100mhz);
      n = ecnt - e0;
      total++;
      if ({sw_en, pause, clear} !== 3'b010)
        $display("FAIL to_race n=%0d: got %b expected 010",
                 n, {sw_en, pause, clear});
      else passed++;
      if (n == 4) time_out = 1'b1;
    end
    key_left = 1'b0;
    time_out = 1'b0;
    repeat (8) @(negedge clk_100mhz);
  endtask

  task automatic test_reset_mid;
    int n;
    int e0;
    logic [3:0] exp;
    key_up = 1'b1;
    e0 = ecnt;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk_100mhz);
      n = ecnt - e0;
      total++;
      if (clear !== (n >= 7))
        $display("FAIL rmid_clear n=%0d: got %b expected %b",
                 n, clear, (n >= 7));
      else passed++;
      if (n == 8) key_left = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk_100mhz);
    total++;
    if ({sw_en, pause, clear, key_evt} !== 4'b0000)
      $display("FAIL rmid_reset: got %b expected 0000",
               {sw_en, pause, clear, key_evt});
    else passed++;
    rst    = 1'b0;
    key_up = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_100mhz);
      n   = ecnt;
      exp = {(n >= 7), 1'b0, 1'b0, (n == 7)};
      total++;
      if ({sw_en, pause, clear, key_evt} !== exp)
        $display("FAIL rmid_held n=%0d: got %b expected %b",
                 n, {sw_en, pause, clear, key_evt}, exp);
      else passed++;
    end
    key_left = 1'b0;
    repeat (8) @(negedge clk_100mhz);
  endtask

  task automatic test_random;
    int hl[4];
    logic [3:0] v;
    logic [3:0] mdl;
    v = {time_out, key_up, key_down, key_left};
    for (int k = 0; k < 4; k++) hl[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_100mhz);
      mdl = {m_sw, m_pause, m_clear, m_evt};
      total++;
      if ({sw_en, pause, clear, key_evt} !== mdl)
        $display("FAIL random c=%0d: got %b expected %b",
                 c, {sw_en, pause, clear, key_evt}, mdl);
      else passed++;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 799) == 0) rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (hl[k] == 0) begin
          v[k]  = ~v[k];
          hl[k] = (k == 3) ? int'($urandom_range(1, 30))
                           : int'($urandom_range(1, 12));
        end else begin
          hl[k]--;
        end
      end
      {time_out, key_up, key_down, key_left} = v;
    end
  endtask

  initial begin
    test_reset();
    test_left();
    test_both();
    test_clear();
    test_glitch();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/stopwatch_keys.md
# stopwatch_keys

Button front-end for the stopwatch: takes the three raw board push-buttons and produces the `sw_en`, `pause` and `clear` command levels consumed by the stopwatch counter/control block.
- Each button is synchronised and debounced in the 100 MHz domain.
- Left and down presses toggle the run and pause levels.
- An up press issues a `clear` level stretched long enough to be sampled by the 100 Hz counter clock.
- A rising `time_out` from the counter automatically stops the run level.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive clock cycles (10 ms) a synchronised key must differ from its debounced state before the change is accepted; must be ≥ 2.
- `CLEAR_HOLD_CYCLES`, default 2_000_000: cycles `clear` is held high (two 100 Hz periods); must be ≥ 1.
- `CNT_W`, default 21: width of the debounce and hold counters; must hold `max(DEBOUNCE_CYCLES, CLEAR_HOLD_CYCLES)`.

Ports (one clock; reset is synchronous and active-high):
- `clk_100mhz` in 1: system clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_left` in 1: raw start/stop button, asynchronous, 1 = pressed.
- `key_down` in 1: raw pause button, asynchronous, 1 = pressed.
- `key_up` in 1: raw clear button, asynchronous, 1 = pressed.
- `time_out` in 1: preset-reached flag from the counter (100 Hz domain), treated as asynchronous.
- `sw_en` out 1: run level, registered.
- `pause` out 1: display-freeze level, registered.
- `clear` out 1: clear level, registered.
- `key_evt` out 1: one-cycle pulse on any accepted press (left, down or up), registered.

## Operation
- **Synchronisers:** 2-flop synchroniser on each of `key_left`, `key_down`, `key_up`, `time_out`. A third flop holds the previous synchronised `time_out` for rise detection.
- **Debounce, per key:** state `db` (reset 0) and counter `cnt` (reset 0).
  - If the synchronised value equals `db`: `cnt` <= 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `db` <= synchronised value, `cnt` <= 0.
  - Else: `cnt` <= `cnt+1`.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles is discarded. Releases are debounced the same way and produce no action.
- **Press:** `db` rising (`db` & ~`db_d`, with `db_d` a 1-cycle delay of `db`) gives a one-cycle `press_*` pulse.
- **FSM, states IDLE and CLEARING:**
  - IDLE:
    - `press_left` toggles `sw_en`.
    - `press_down` toggles `pause`.
    - `press_up` moves to CLEARING: `clear` <= 1, `sw_en` <= 0, `pause` <= 0, hold counter <= 0.
  - CLEARING:
    - Hold counter increments each cycle.
    - At `CLEAR_HOLD_CYCLES-1`: `clear` <= 0, return to IDLE.
    - All presses are ignored (no toggle, no retrigger, no `key_evt`).
- **Timeout:** a synchronised `time_out` rise forces `sw_en` <= 0 in either state; `pause` is unaffected.
- **Simultaneous events:**
  - `time_out` rise with `press_left`: `sw_en` = 0 (timeout wins).
  - `press_up` with `press_left`/`press_down`: clear wins, both levels become 0.
  - `press_left` with `press_down` in IDLE: both toggle.
- **`key_evt`:** equals the OR of the presses accepted this cycle, registered; it is 0 for presses ignored in CLEARING.
- **Reset:** all outputs 0, FSM IDLE, all `db`, `db_d`, synchroniser flops and counters 0. A key held through reset is accepted as a press `DEBOUNCE_CYCLES` cycles after reset deasserts plus the synchroniser latency.

## Timing
- **Key latency:** raw key first sampled high at edge 1 → `db` high at edge `DEBOUNCE_CYCLES+2` → `sw_en`/`pause`/`clear`/`key_evt` update at edge `DEBOUNCE_CYCLES+3`. Raw input must stay stable for the whole interval.
- **Clear width:** `clear` is high for exactly `CLEAR_HOLD_CYCLES` cycles.
- **Timeout latency:** `time_out` first sampled high at edge 1 → `sw_en` low after edge 3.
- **Minimum press interval:** one full press/release cycle takes ≥ 2·`DEBOUNCE_CYCLES` cycles. Faster toggling is filtered, never counted twice.

## Test plan
Use `DEBOUNCE_CYCLES=4`, `CLEAR_HOLD_CYCLES=8`.
1. Reset, then hold `key_left` high for 20 cycles → `sw_en` 0→1 at edge 7, single `key_evt` pulse. Release, press again → `sw_en` 1→0.
2. `key_down` high-low bursts of 3 cycles, repeated 5 times → `pause` stays 0, `key_evt` never asserts. Then a 10-cycle press → `pause` = 1.
3. `sw_en`=1 and `pause`=1, then press `key_up` → `clear` = 1 for exactly 8 cycles with `sw_en`=`pause`=0. A `key_left` press landing inside that window → no toggle, no `key_evt`.
4. `sw_en`=1, raise `time_out` → `sw_en` = 0 three edges later. Same test with the `key_left` accept edge coinciding → `sw_en` = 0.
5. `key_left` and `key_down` raised on the same cycle from IDLE → both `sw_en` and `pause` become 1 on the same edge, one `key_evt` pulse.
6. Assert `rst` mid-CLEARING and mid-debounce → next cycle all outputs 0. `key_left` still held after `rst` drops → `sw_en` = 1 at `DEBOUNCE_CYCLES+3` edges after deassert.
